veri_bellek_denetleyici: RTL and testbench

- Sits directly downstream of the bellek islem birimi (BIB). It consumes the BIB data request (word-aligned address, write data, byte mask, select) and drives `bib_durdur` and load data back to it.
- Stores go into a posted write buffer and are drained to the external data memory over a req/ack bus.
- Loads first drain the buffer to preserve program order, then issue a blocking read.

---
 rtl/veri_bellek_denetleyici.sv | 149 ++++++++++++++
 tb/tb_veri_bellek_denetleyici.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/veri_bellek_denetleyici.sv
// Data-memory controller behind the BIB: posted write buffer drained over a req/ack bus,
// and blocking loads that first drain the buffer so memory sees program order.
module veri_bellek_denetleyici #(
    parameter int TAMPON_DERINLIK = 4,
    parameter int ADR_BIT         = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               bib_sec_i,
    input  logic [ADR_BIT-1:0] bib_adr_i,
    input  logic [31:0]        bib_veri_i,
    input  logic [3:0]         bib_veri_maske_i,
    output logic [31:0]        bib_veri_o,
    output logic               bib_durdur_o,
    output logic               bellek_istek_o,
    output logic               bellek_yaz_o,
    output logic [ADR_BIT-1:0] bellek_adr_o,
    output logic [31:0]        bellek_veri_o,
    output logic [3:0]         bellek_maske_o,
    input  logic               bellek_gecerli_i,
    input  logic [31:0]        bellek_veri_i,
    output logic               tampon_bos_o
);
    localparam int PB = $clog2(TAMPON_DERINLIK);
    localparam logic [PB:0] DOLU = (PB + 1)'(TAMPON_DERINLIK);

    typedef enum logic [1:0] {BOS, BOSALT, OKU, YANIT} durum_e;

    durum_e             durum_q;
    logic [ADR_BIT-1:0] tadr_q   [TAMPON_DERINLIK];
    logic [31:0]        tveri_q  [TAMPON_DERINLIK];
    logic [3:0]         tmaske_q [TAMPON_DERINLIK];
    logic [PB-1:0]      yaz_ptr_q, oku_ptr_q;
    logic [PB:0]        sayac_q, sayac_d;
    logic [ADR_BIT-1:0] oku_adr_q;
    logic [31:0]        okuma_q;
    logic               iptal_q;

    logic yukle, sakla, push, pop, yazma_istek, okuma_istek, okuma_ack;

    assign yukle       = bib_sec_i && (bib_veri_maske_i == 4'b0000);
    assign sakla       = bib_sec_i && (bib_veri_maske_i != 4'b0000);
    assign push        = sakla && (sayac_q != DOLU);
    // Writes are never drained while a read owns the bus, so at most one request is outstanding.
    assign yazma_istek = (sayac_q != '0) && (durum_q != OKU);
    assign okuma_istek = (durum_q == OKU);
    assign pop         = yazma_istek && bellek_gecerli_i;
    assign okuma_ack   = okuma_istek && bellek_gecerli_i;

    assign bib_durdur_o = (sakla && (sayac_q == DOLU)) || (yukle && (durum_q != YANIT));
    assign bib_veri_o   = okuma_q;
    assign tampon_bos_o = (sayac_q == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        bellek_istek_o = 1'b0;
        bellek_yaz_o   = 1'b0;
        bellek_adr_o   = '0;
        bellek_veri_o  = '0;
        bellek_maske_o = 4'b0000;
        if (yazma_istek) begin
            bellek_istek_o = 1'b1;
            bellek_yaz_o   = 1'b1;
            bellek_adr_o   = tadr_q[oku_ptr_q];
            bellek_veri_o  = tveri_q[oku_ptr_q];
            bellek_maske_o = tmaske_q[oku_ptr_q];
        end else if (okuma_istek) begin
            bellek_istek_o = 1'b1;
            bellek_adr_o   = oku_adr_q;
        end
    end

    always_comb begin
        sayac_d = sayac_q;
        if (push && !pop)
            sayac_d = sayac_q + 1'b1;
        else if (pop && !push)
            sayac_d = sayac_q - 1'b1;
    end

    // NOTE: buffer storage carries no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tadr_q[yaz_ptr_q]   <= bib_adr_i;
            tveri_q[yaz_ptr_q]  <= bib_veri_i;
            tmaske_q[yaz_ptr_q] <= bib_veri_maske_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
            sayac_q   <= '0;
        end else begin
            if (push)
                yaz_ptr_q <= yaz_ptr_q + 1'b1;
            if (pop)
                oku_ptr_q <= oku_ptr_q + 1'b1;
            sayac_q <= sayac_d;
        end
    end

    // Load sequencer; the read address is captured on entry to OKU so a flush cannot move it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q   <= BOS;
            oku_adr_q <= '0;
            okuma_q   <= '0;
            iptal_q   <= 1'b0;
        end else begin
            case (durum_q)
                BOS: begin
                    if (yukle) begin
                        if (sayac_q != '0) begin
                            durum_q <= BOSALT;
                        end else begin
                            durum_q   <= OKU;
                            oku_adr_q <= bib_adr_i;
                        end
                    end
                end
                BOSALT: begin
                    if (!bib_sec_i) begin
                        durum_q <= BOS;
                    end else if (sayac_d == '0) begin
                        durum_q   <= OKU;
                        oku_adr_q <= bib_adr_i;
                    end
                end
                OKU: begin
                    if (!bib_sec_i)
                        iptal_q <= 1'b1;
                    if (okuma_ack) begin
                        iptal_q <= 1'b0;
                        if (iptal_q || !bib_sec_i) begin
                            durum_q <= BOS;
                        end else begin
                            okuma_q <= bellek_veri_i;
                            durum_q <= YANIT;
                        end
                    end
                end
                YANIT: durum_q <= BOS;
                default: durum_q <= BOS;
            endcase
        end
    end
endmodule

// File: tb/tb_veri_bellek_denetleyici.sv
// Scoreboard bench for veri_bellek_denetleyici: stimulus queues expected bus transactions
// and load results, a memory model acks requests, and a monitor compares them.
module tb_veri_bellek_denetleyici;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bib_sec_i;
    logic [31:0] bib_adr_i;
    logic [31:0] bib_veri_i;
    logic [3:0]  bib_veri_maske_i;
    logic [31:0] bib_veri_o;
    logic        bib_durdur_o;
    logic        bellek_istek_o;
    logic        bellek_yaz_o;
    logic [31:0] bellek_adr_o;
    logic [31:0] bellek_veri_o;
    logic [3:0]  bellek_maske_o;
    logic        bellek_gecerli_i;
    logic [31:0] bellek_veri_i;
    logic        tampon_bos_o;

    veri_bellek_denetleyici #(.TAMPON_DERINLIK(4), .ADR_BIT(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bib_sec_i(bib_sec_i), .bib_adr_i(bib_adr_i), .bib_veri_i(bib_veri_i),
        .bib_veri_maske_i(bib_veri_maske_i), .bib_veri_o(bib_veri_o), .bib_durdur_o(bib_durdur_o),
        .bellek_istek_o(bellek_istek_o), .bellek_yaz_o(bellek_yaz_o), .bellek_adr_o(bellek_adr_o),
        .bellek_veri_o(bellek_veri_o), .bellek_maske_o(bellek_maske_o),
        .bellek_gecerli_i(bellek_gecerli_i), .bellek_veri_i(bellek_veri_i),
        .tampon_bos_o(tampon_bos_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        yaz;
        logic [31:0] adr;
        logic [31:0] veri;
        logic [3:0]  maske;
    } islem_t;

    islem_t      sb[$];
    logic [31:0] yuk_q[$];
    logic [31:0] mem[logic [31:0]];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int son_oku_ack = -10;
    int okuma_sayisi = 0;

    int  gecikme  = 1;
    bit  tut      = 1'b0;
    bit  sahte_ack = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        vectors++;
        if (gercek !== beklenen) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    // Memory model: acks a request after `gecikme` cycles, one-cycle ack pulse.
    initial begin
        int bekle;
        logic [31:0] eski;
        bekle = 0;
        bellek_gecerli_i = 1'b0;
        bellek_veri_i = '0;
        forever begin
            @(negedge clk_i);
            if (bellek_gecerli_i) begin
                bellek_gecerli_i = 1'b0;
                bekle = 0;
            end else if (sahte_ack) begin
                sahte_ack = 1'b0;
                bellek_gecerli_i = 1'b1;
                bellek_veri_i = 32'hBADC0DE5;
            end else if (bellek_istek_o && !tut && rst_i) begin
                if (bekle >= gecikme - 1) begin
                    bellek_gecerli_i = 1'b1;
                    eski = mem.exists(bellek_adr_o) ? mem[bellek_adr_o] : 32'h0;
                    if (bellek_yaz_o) begin
                        for (int b = 0; b < 4; b++)
                            if (bellek_maske_o[b]) eski[8*b +: 8] = bellek_veri_o[8*b +: 8];
                        mem[bellek_adr_o] = eski;
                        bellek_veri_i = 32'h0;
                    end else begin
                        bellek_veri_i = eski;
                    end
                end else begin
                    bekle++;
                end
            end else begin
                bekle = 0;
            end
        end
    end

    // Monitor: checks every acked bus transaction and every completed load.
    initial begin
        islem_t e;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_i && bellek_istek_o && bellek_gecerli_i) begin
                if (!bellek_yaz_o) begin
                    son_oku_ack = cyc;
                    okuma_sayisi++;
                end
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL bus_unexpected: got yaz=%0b adr=%h, expected no transaction",
                             bellek_yaz_o, bellek_adr_o);
                end else begin
                    e = sb.pop_front();
                    check("bus_yaz", 32'(bellek_yaz_o), 32'(e.yaz));
                    check("bus_adr", bellek_adr_o, e.adr);
                    check("bus_maske", 32'(bellek_maske_o), 32'(e.maske));
                    if (e.yaz) check("bus_veri", bellek_veri_o, e.veri);
                end
            end
            if (rst_i && bib_sec_i && bib_veri_maske_i == 4'b0000 && !bib_durdur_o) begin
                if (yuk_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL load_unexpected: got %h, expected no load completion", bib_veri_o);
                end else begin
                    check("load_veri", bib_veri_o, yuk_q.pop_front());
                    check("load_ack_plus_1", 32'(cyc), 32'(son_oku_ack + 1));
                end
            end
        end
    end

    task automatic bib_islem(input logic [31:0] adr, veri, input logic [3:0] maske,
                             output int durus);
        bib_sec_i = 1'b1;
        bib_adr_i = adr;
        bib_veri_i = veri;
        bib_veri_maske_i = maske;
        durus = 0;
        while (1) begin
            @(negedge clk_i);
            if (!bib_durdur_o) break;
            durus++;
            if (durus > 500) begin
                check("bib_timeout", 32'(durus), 32'd0);
                break;
            end
            @(posedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        bib_sec_i = 1'b0;
        bib_veri_maske_i = 4'b0000;
    endtask

    task automatic sw(input logic [31:0] adr, veri, input logic [3:0] maske, output int durus);
        sb.push_back('{1'b1, adr, veri, maske});
        bib_islem(adr, veri, maske, durus);
    endtask

    task automatic lw(input logic [31:0] adr, beklenen);
        int d;
        sb.push_back('{1'b0, adr, 32'h0, 4'b0000});
        yuk_q.push_back(beklenen);
        bib_islem(adr, 32'h0, 4'b0000, d);
    endtask

    task automatic bekle_bos(input string ad);
        int n = 0;
        while (!(tampon_bos_o && sb.size() == 0 && yuk_q.size() == 0) && n < 1000) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check(ad, 32'(tampon_bos_o && sb.size() == 0 && yuk_q.size() == 0), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d, d5, okuma_once;
        rst_i = 1'b0;
        bib_sec_i = 1'b0;
        bib_adr_i = '0;
        bib_veri_i = '0;
        bib_veri_maske_i = 4'b0000;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_istek", 32'(bellek_istek_o), 32'd0);
        check("rst_yaz", 32'(bellek_yaz_o), 32'd0);
        check("rst_adr", bellek_adr_o, 32'd0);
        check("rst_veri", bellek_veri_o, 32'd0);
        check("rst_maske", 32'(bellek_maske_o), 32'd0);
        check("rst_bos", 32'(tampon_bos_o), 32'd1);
        check("rst_durdur", 32'(bib_durdur_o), 32'd0);
        check("rst_bib_veri", bib_veri_o, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: single store, presented the following cycle.
        gecikme = 2;
        sw(32'h100, 32'hDEADBEEF, 4'b1111, d);
        check("t1_durus", 32'(d), 32'd0);
        check("t1_istek", 32'(bellek_istek_o), 32'd1);
        check("t1_adr", bellek_adr_o, 32'h100);
        check("t1_veri", bellek_veri_o, 32'hDEADBEEF);
        check("t1_maske", 32'(bellek_maske_o), 32'hF);
        bekle_bos("t1_bos");

        // 2: five stores with acks held off; the fifth stalls until the first ack.
        gecikme = 1;
        tut = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sw(32'h20 + 32'(4 * i), 32'hA0 + 32'(i), 4'b1111, d);
            check("t2_durus", 32'(d), 32'd0);
        end
        check("t2_dolu_bos", 32'(tampon_bos_o), 32'd0);
        fork
            sw(32'h30, 32'hA4, 4'b0011, d5);
            begin
                repeat (6) @(posedge clk_i);
                #1;
                tut = 1'b0;
            end
        join
        check("t2_durus5_ge5", 32'(d5 >= 5), 32'd1);
        bekle_bos("t2_bos");

        // 3: two buffered stores, then a load with 3-cycle memory latency.
        gecikme = 3;
        mem[32'h200] = 32'h12345678;
        sw(32'h10, 32'h11111111, 4'b1111, d);
        sw(32'h14, 32'h22222222, 4'b1100, d);
        lw(32'h200, 32'h12345678);
        bekle_bos("t3_bos");

        // 4: store then load of the same word returns the stored data.
        gecikme = 2;
        sw(32'h300, 32'hCAFEF00D, 4'b1111, d);
        lw(32'h300, 32'hCAFEF00D);
        bekle_bos("t4_bos");

        // 5: reset while a read is outstanding, then a late ack.
        gecikme = 30;
        sb.push_back('{1'b0, 32'h400, 32'h0, 4'b0000});
        bib_sec_i = 1'b1;
        bib_adr_i = 32'h400;
        bib_veri_maske_i = 4'b0000;
        d = 0;
        while (!(bellek_istek_o && !bellek_yaz_o) && d < 50) begin
            @(posedge clk_i);
            #1;
            d++;
        end
        check("t5_oku_basladi", 32'(bellek_istek_o && !bellek_yaz_o), 32'd1);
        rst_i = 1'b0;
        bib_sec_i = 1'b0;
        #1;
        check("t5_rst_istek", 32'(bellek_istek_o), 32'd0);
        check("t5_rst_adr", bellek_adr_o, 32'd0);
        check("t5_rst_durdur", 32'(bib_durdur_o), 32'd0);
        check("t5_rst_bos", 32'(tampon_bos_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        sb.delete();
        sahte_ack = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("t5_gec_ack_istek", 32'(bellek_istek_o), 32'd0);
        check("t5_gec_ack_bos", 32'(tampon_bos_o), 32'd1);
        check("t5_gec_ack_veri", bib_veri_o, 32'd0);

        // 6: load flushed while draining: no read, buffer still drains.
        gecikme = 2;
        tut = 1'b1;
        sw(32'h500, 32'h55, 4'b1111, d);
        sw(32'h504, 32'h66, 4'b1111, d);
        okuma_once = okuma_sayisi;
        bib_sec_i = 1'b1;
        bib_adr_i = 32'h600;
        bib_veri_maske_i = 4'b0000;
        repeat (3) @(posedge clk_i);
        #1;
        check("t6_durdur_bosalt", 32'(bib_durdur_o), 32'd1);
        bib_sec_i = 1'b0;
        #1;
        check("t6_durdur_flush", 32'(bib_durdur_o), 32'd0);
        tut = 1'b0;
        bekle_bos("t6_bos");
        repeat (10) @(posedge clk_i);
        #1;
        check("t6_okuma_yok", 32'(okuma_sayisi - okuma_once), 32'd0);
        check("t6_istek_yok", 32'(bellek_istek_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
